// File: rtl/doi_pkg.sv
// Shared types and constants for the operand-issue buffer: command layout,
// occupancy states, legal mode limit and default depth.
package doi_pkg;

  localparam int         DOI_DEPTH_DEFAULT = 4;
  localparam logic [3:0] DOI_MODE_MAX      = 4'd4;

  typedef struct packed {
    logic [7:0] op1;
    logic [7:0] op2;
    logic [3:0] mode;
  } cmd_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_e;

  function automatic logic mode_legal(input logic [3:0] mode);
    return mode <= DOI_MODE_MAX;
  endfunction

endpackage

// File: rtl/dccc_cmd_fifo.sv
// Command storage with wrapping read/write pointers and a registered head entry
// that drives the downstream stage directly.
module dccc_cmd_fifo
  import doi_pkg::*;
#(
  parameter int DEPTH = DOI_DEPTH_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic head_load,
  input  cmd_t wr_data,
  output cmd_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;

  assign rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;

  // NOTE: storage is deliberately not reset; occupancy state guards every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // When the buffer is empty after this cycle's pop, the incoming command
  // becomes the head; otherwise the next stored entry is promoted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
    end else if (!flush) begin
      if (push && head_load) head <= wr_data;
      else if (pop)          head <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/dccc_operand_issue.sv
// Operand issue buffer: FIFO of commands feeding a downstream case stage.
// Optional build macro DOI_MODE_CHECK_EN rejects modes above DOI_MODE_MAX.
module dccc_operand_issue
  import doi_pkg::*;
#(
  parameter int DEPTH = DOI_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        doi_in_valid,
  output logic        doi_in_ready,
  input  logic [7:0]  doi_in_op1,
  input  logic [7:0]  doi_in_op2,
  input  logic [3:0]  doi_in_mode,
  input  logic        doi_flush,
  output logic [7:0]  doi_out_op1,
  output logic [7:0]  doi_out_op2,
  output logic [3:0]  doi_out_mode,
  output logic        doi_out_valid,
  input  logic        doi_out_ready,
  output logic [15:0] doi_issue_cnt,
  output logic        doi_err_sticky
);

  localparam int CW = $clog2(DEPTH + 1);

  state_e        state;
  state_e        state_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          accept;
  logic          mode_ok;
  logic          push;
  logic          pop;
  logic          head_load;
  cmd_t          in_cmd;
  cmd_t          head;

  assign doi_in_ready  = (state != FULL);
  assign doi_out_valid = (state != EMPTY);

  assign in_cmd = '{op1: doi_in_op1, op2: doi_in_op2, mode: doi_in_mode};

`ifdef DOI_MODE_CHECK_EN
  assign mode_ok = mode_legal(doi_in_mode);
`else
  assign mode_ok = 1'b1;
`endif

  assign accept    = doi_in_valid && doi_in_ready;
  assign push      = accept && mode_ok && !doi_flush;
  assign pop       = doi_out_valid && doi_out_ready && !doi_flush;
  assign head_load = (count == CW'(pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (doi_flush) begin
      state_nxt = EMPTY;
      count_nxt = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            state_nxt = PARTIAL;
            count_nxt = CW'(1);
          end
        end
        PARTIAL: begin
          if (push && !pop) begin
            count_nxt = count + CW'(1);
            if (count_nxt == CW'(DEPTH)) state_nxt = FULL;
          end else if (pop && !push) begin
            count_nxt = count - CW'(1);
            if (count == CW'(1)) state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt = PARTIAL;
            count_nxt = count - CW'(1);
          end
        end
        default: begin
          state_nxt = EMPTY;
          count_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      doi_issue_cnt <= '0;
    else if (pop) doi_issue_cnt <= doi_issue_cnt + 16'd1;
  end

`ifdef DOI_MODE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     doi_err_sticky <= 1'b0;
    else if (doi_flush)          doi_err_sticky <= 1'b0;
    else if (accept && !mode_ok) doi_err_sticky <= 1'b1;
  end
`else
  assign doi_err_sticky = 1'b0;
`endif

  dccc_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (doi_flush),
    .head_load (head_load),
    .wr_data   (in_cmd),
    .head      (head)
  );

  assign doi_out_op1  = head.op1;
  assign doi_out_op2  = head.op2;
  assign doi_out_mode = head.mode;

endmodule
